// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage data memory access unit:
// access size encodings, FSM state type, lane offsets and the alignment rule.
package mem_access_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Byte lane offsets within a little-endian 32-bit word
  localparam logic [1:0] OFF_B0 = 2'd0;
  localparam logic [1:0] OFF_B1 = 2'd1;
  localparam logic [1:0] OFF_B2 = 2'd2;
  localparam logic [1:0] OFF_B3 = 2'd3;

  // Half-word lane offsets
  localparam logic [1:0] OFF_H0 = 2'd0;
  localparam logic [1:0] OFF_H1 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } mem_state_e;

  // Halves must sit on an even address, words on a multiple of four
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    return ((size == SZ_HALF) && offset[0]) || ((size == SZ_WORD) && (offset != 2'd0));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signals of the MEM-stage access unit.
//
// Request handshake: a request transfers on a rising clk edge where
// req_valid && req_ready are both high. The requester holds req_valid and all
// req_* fields stable until that edge; req_ready never depends on req_valid.
// resp_valid is a one-cycle pulse with no backpressure.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_error;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_writeData;
  logic              mem_memRead;
  logic              mem_memWrite;
  logic [31:0]       mem_readData;

  // The access unit: target of requests, initiator of memory cycles
  modport master (
    input  req_valid, req_load, req_store, req_size, req_signed, req_addr, req_wdata,
    input  mem_readData,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_addr, mem_writeData, mem_memRead, mem_memWrite
  );

  // The surrounding pipeline and memory
  modport slave (
    output req_valid, req_load, req_store, req_size, req_signed, req_addr, req_wdata,
    output mem_readData,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_addr, mem_writeData, mem_memRead, mem_memWrite
  );
endinterface

// File: rtl/lane_align.sv
// Combinational lane handling: extracts and extends load data from a memory
// word, and merges sub-word store data into the old word.
module lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed lane, extend it for loads and replace it for stores
  always_comb begin
    byte_lane  = 8'h00;
    half_lane  = (offset == OFF_H1) ? rword[31:16] : rword[15:0];
    load_data  = 32'h0;
    merge_data = rword;

    case (offset)
      OFF_B0:  byte_lane = rword[7:0];
      OFF_B1:  byte_lane = rword[15:8];
      OFF_B2:  byte_lane = rword[23:16];
      OFF_B3:  byte_lane = rword[31:24];
      default: byte_lane = 8'h00;
    endcase

    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
        case (offset)
          OFF_B0:  merge_data[7:0]   = wdata[7:0];
          OFF_B1:  merge_data[15:8]  = wdata[7:0];
          OFF_B2:  merge_data[23:16] = wdata[7:0];
          OFF_B3:  merge_data[31:24] = wdata[7:0];
          default: merge_data        = rword;
        endcase
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
        if (offset == OFF_H1) merge_data[31:16] = wdata[15:0];
        else                  merge_data[15:0]  = wdata[15:0];
      end
      SZ_WORD: begin
        load_data  = rword;
        merge_data = wdata;
      end
      default: begin
        load_data  = 32'h0;
        merge_data = rword;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory initiator: accepts one byte-addressed load/store at a
// time, runs word-indexed read / write / read-modify-write cycles and returns
// aligned load data with an error flag.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  mem_access_unit_if.master bus,
  output mem_state_e state_dbg
);

  mem_state_e        state;
  logic [1:0]        r_offset;
  logic [1:0]        r_size;
  logic              r_signed;
  logic              r_store;
  logic [31:0]       r_wdata;

  logic [ADDR_W-1:0] word_idx;
  logic              acc_err;
  logic              acc_noop;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  assign word_idx      = {2'b00, bus.req_addr[ADDR_W-1:2]};
  assign bus.req_ready = (state == ST_IDLE) && !reset;
  assign state_dbg     = state;

  // Classify the incoming request: any error condition, or neither load nor store
  always_comb begin
    acc_err  = is_misaligned(bus.req_size, bus.req_addr[1:0]) ||
               (word_idx >= ADDR_W'(DEPTH)) ||
               (bus.req_size == SZ_RSVD) ||
               (bus.req_load && bus.req_store);
    acc_noop = !bus.req_load && !bus.req_store;
  end

  // Lane extraction works on the live read word so READ can capture its result
  lane_align u_lane_align (
    .offset     (r_offset),
    .size       (r_size),
    .sign_ext   (r_signed),
    .rword      (bus.mem_readData),
    .wdata      (r_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Control FSM with registered memory strobes and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      r_offset          <= 2'd0;
      r_size            <= SZ_BYTE;
      r_signed          <= 1'b0;
      r_store           <= 1'b0;
      r_wdata           <= 32'h0;
      bus.resp_valid    <= 1'b0;
      bus.resp_rdata    <= 32'h0;
      bus.resp_error    <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_writeData <= 32'h0;
      bus.mem_memRead   <= 1'b0;
      bus.mem_memWrite  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_offset <= bus.req_addr[1:0];
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_store  <= bus.req_store;
            r_wdata  <= bus.req_wdata;
            if (acc_err || acc_noop) begin
              // Nothing touches memory; answer on the next cycle
              state          <= ST_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= 32'h0;
              bus.resp_error <= acc_err;
            end else if (bus.req_load || (bus.req_size != SZ_WORD)) begin
              // Loads and sub-word stores both need the current word first
              state           <= ST_READ;
              bus.mem_addr    <= word_idx;
              bus.mem_memRead <= 1'b1;
            end else begin
              state             <= ST_WRITE;
              bus.mem_addr      <= word_idx;
              bus.mem_writeData <= bus.req_wdata;
              bus.mem_memWrite  <= 1'b1;
            end
          end
        end

        ST_READ: begin
          bus.mem_memRead <= 1'b0;
          if (r_store) begin
            // Keep mem_addr; write back the old word with one lane replaced
            state             <= ST_WRITE;
            bus.mem_writeData <= merge_data;
            bus.mem_memWrite  <= 1'b1;
          end else begin
            state          <= ST_RESP;
            bus.mem_addr   <= '0;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= load_data;
            bus.resp_error <= 1'b0;
          end
        end

        ST_WRITE: begin
          state             <= ST_RESP;
          bus.mem_addr      <= '0;
          bus.mem_writeData <= 32'h0;
          bus.mem_memWrite  <= 1'b0;
          bus.resp_valid    <= 1'b1;
          bus.resp_rdata    <= 32'h0;
          bus.resp_error    <= 1'b0;
        end

        ST_RESP: begin
          state          <= ST_IDLE;
          bus.resp_valid <= 1'b0;
          bus.resp_rdata <= 32'h0;
          bus.resp_error <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64-word behavioural data memory.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic       clk;
  logic       reset;
  mem_state_e state_dbg;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.DEPTH(64), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory model and strobe monitor ----------------
  logic [31:0] mem_model [0:63];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          overlap_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  assign bus.mem_readData = (bus.mem_memRead && (bus.mem_addr < 32'd64)) ?
                            mem_model[bus.mem_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (bus.mem_memRead) rd_cnt <= rd_cnt + 1;
    if (bus.mem_memWrite) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus.mem_addr;
      last_wr_data <= bus.mem_writeData;
      if (bus.mem_addr < 32'd64) mem_model[bus.mem_addr[5:0]] <= bus.mem_writeData;
    end
    if (bus.mem_memRead && bus.mem_memWrite) overlap_cnt <= overlap_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with the unit idle; returns at posedge+1 back in IDLE.
  task automatic do_req(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err);
    int n;
    bus.req_valid  = 1'b1;
    bus.req_load   = ld;
    bus.req_store  = st;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_load  = 1'b0;
    bus.req_store = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_error;
    @(posedge clk); #1;
  endtask

  task automatic expect_req(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                            input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                            input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                            input int exp_rd, input int exp_wr);
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          rd0;
    int          wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    do_req(ld, st, sz, sg, addr, wd, lat, rdata, err);
    check({tag, "_lat"},   32'(lat),            32'(exp_lat));
    check({tag, "_rdata"}, rdata,               exp_rdata);
    check({tag, "_err"},   {31'h0, err},        {31'h0, exp_err});
    check({tag, "_rds"},   32'(rd_cnt - rd0),   32'(exp_rd));
    check({tag, "_wrs"},   32'(wr_cnt - wr0),   32'(exp_wr));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] got [2];
    int          nresp;
    bit          arm;
    int          wr_before;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_load   = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_size   = SZ_BYTE;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_low", {31'h0, bus.req_ready}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_state",  32'(state_dbg),                32'(ST_IDLE));
    check("rst_ready",  {31'h0, bus.req_ready},        32'h1);
    check("rst_rvalid", {31'h0, bus.resp_valid},       32'h0);
    check("rst_rdata",  bus.resp_rdata,                32'h0);
    check("rst_err",    {31'h0, bus.resp_error},       32'h0);
    check("rst_strobe", {30'h0, bus.mem_memRead, bus.mem_memWrite}, 32'h0);
    check("rst_maddr",  bus.mem_addr,                  32'h0);
    check("rst_wdata",  bus.mem_writeData,             32'h0);

    // Word store then word load
    expect_req("st_word", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1);
    check("st_word_waddr", last_wr_addr, 32'h4);
    check("st_word_wdata", last_wr_data, 32'hDEADBEEF);
    expect_req("ld_word", 1'b1, 1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1, 0);

    // Byte read-modify-write into 0x11223344 (upper wdata bits must be ignored)
    expect_req("st_w4", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, 2, 32'h0, 1'b0, 0, 1);
    expect_req("st_byte", 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h123456AA, 3, 32'h0, 1'b0, 1, 1);
    check("st_byte_waddr", last_wr_addr, 32'h4);
    check("st_byte_wdata", last_wr_data, 32'h11AA3344);
    expect_req("ld_sb12", 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h12, 32'h0, 2, 32'hFFFFFFAA, 1'b0, 1, 0);
    expect_req("ld_ub12", 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, 2, 32'h000000AA, 1'b0, 1, 0);
    expect_req("ld_sb13", 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 2, 32'h00000011, 1'b0, 1, 0);
    expect_req("ld_ub10", 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 2, 32'h00000044, 1'b0, 1, 0);

    // Half loads and a half read-modify-write
    expect_req("st_w4b", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h8001FFFF, 2, 32'h0, 1'b0, 0, 1);
    expect_req("ld_sh12", 1'b1, 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 2, 32'hFFFF8001, 1'b0, 1, 0);
    expect_req("ld_uh12", 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 2, 32'h00008001, 1'b0, 1, 0);
    expect_req("ld_sh10", 1'b1, 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 2, 32'hFFFFFFFF, 1'b0, 1, 0);
    expect_req("st_half", 1'b0, 1'b1, SZ_HALF, 1'b0, 32'h10, 32'hABCD1234, 3, 32'h0, 1'b0, 1, 1);
    check("st_half_wdata", last_wr_data, 32'h80011234);

    // Highest in-range word
    expect_req("st_top", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'hFC, 32'h5A5A0001, 2, 32'h0, 1'b0, 0, 1);
    check("st_top_waddr", last_wr_addr, 32'h3F);
    expect_req("ld_top", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'hFC, 32'h0, 2, 32'h5A5A0001, 1'b0, 1, 0);

    // Error and no-op requests: one cycle, no strobes
    expect_req("e_mis_w",  1'b1, 1'b0, SZ_WORD, 1'b0, 32'h11,  32'h0, 1, 32'h0, 1'b1, 0, 0);
    expect_req("e_mis_h",  1'b0, 1'b1, SZ_HALF, 1'b0, 32'h13,  32'hFFFF, 1, 32'h0, 1'b1, 0, 0);
    expect_req("e_range",  1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    expect_req("e_rsvd",   1'b1, 1'b0, SZ_RSVD, 1'b0, 32'h10,  32'h0, 1, 32'h0, 1'b1, 0, 0);
    expect_req("e_ldst",   1'b1, 1'b1, SZ_WORD, 1'b0, 32'h10,  32'h0, 1, 32'h0, 1'b1, 0, 0);
    expect_req("noop",     1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0, 1, 32'h0, 1'b0, 0, 0);

    // Back-to-back loads with req_valid held high
    nresp = 0;
    arm   = 1'b0;
    got[0] = 32'h0;
    got[1] = 32'h0;
    bus.req_valid  = 1'b1;
    bus.req_load   = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_size   = SZ_WORD;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h10;
    @(posedge clk); #1;
    bus.req_addr = 32'hFC;
    check("b2b_busy_ready", {31'h0, bus.req_ready}, 32'h0);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (arm) begin
        bus.req_valid = 1'b0;
        arm = 1'b0;
      end
      if (bus.resp_valid && nresp < 2) begin
        got[nresp] = bus.resp_rdata;
        nresp++;
      end
      if (bus.req_valid && nresp == 1 && bus.req_ready) arm = 1'b1;
    end
    bus.req_valid = 1'b0;
    bus.req_load  = 1'b0;
    check("b2b_nresp", 32'(nresp), 32'd2);
    check("b2b_first", got[0], 32'h80011234);
    check("b2b_second", got[1], 32'h5A5A0001);

    // Reset while a byte store is in its READ cycle
    wr_before      = wr_cnt;
    bus.req_valid  = 1'b1;
    bus.req_load   = 1'b0;
    bus.req_store  = 1'b1;
    bus.req_size   = SZ_BYTE;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h77;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    check("rmr_state_read", 32'(state_dbg), 32'(ST_READ));
    check("rmr_rd_strobe", {31'h0, bus.mem_memRead}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rmr_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rmr_strobes", {30'h0, bus.mem_memRead, bus.mem_memWrite}, 32'h0);
    check("rmr_maddr", bus.mem_addr, 32'h0);
    check("rmr_mwdata", bus.mem_writeData, 32'h0);
    check("rmr_resp", {30'h0, bus.resp_valid, bus.resp_error}, 32'h0);
    check("rmr_rdata", bus.resp_rdata, 32'h0);
    check("rmr_ready_in_rst", {31'h0, bus.req_ready}, 32'h0);
    reset = 1'b0;
    #1;
    check("rmr_ready_after", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rmr_no_write", 32'(wr_cnt - wr_before), 32'h0);
    expect_req("rmr_ld", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 2, 32'h80011234, 1'b0, 1, 0);

    check("no_overlap", 32'(overlap_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the word-wide data memory interface, sitting in the MEM pipeline stage.
- Accepts one byte-addressed load or store request at a time from the EX/MEM register.
- Converts the request into word-indexed memory read/write cycles, with read-modify-write for sub-word stores.
- Returns aligned, sign- or zero-extended load data and an error flag to the write-back path.

Parameters:
- DEPTH, 64, number of 32-bit words in the attached data memory; word index range is 0..DEPTH-1.
- ADDR_W, 32, width of the request byte address and the memory word-index port.

Ports:
- clk  in  1  rising-edge clock; only clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_load  in  1  request is a load.
- req_store  in  1  request is a store.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  sign-extend load result (byte/half only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  misaligned, out-of-range, reserved size, or load+store both set.
- mem_addr  out  ADDR_W  word index, equal to req_addr >> 2 zero-extended.
- mem_writeData  out  32  word written to memory.
- mem_memRead  out  1  memory read strobe.
- mem_memWrite  out  1  memory write strobe.
- mem_readData  in  32  memory read word, valid combinationally while mem_memRead is high.

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP.
- Request registers capture addr, size, signed, wdata, load/store and the byte offset (addr[1:0]) on the accept edge.
- req_ready = (state==IDLE) && !reset.
- Accept occurs on a cycle with req_valid && req_ready. Requests are never dropped or reordered.
- Error check is done at accept:
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0;
  - out of range: addr>>2 >= DEPTH;
  - size 11;
  - req_load && req_store.
- Error, or no-op (load=store=0): IDLE -> RESP. No memory strobes, rdata=0, error flag set as checked (no-op gives error=0).
- Load: IDLE -> READ -> RESP.
  - In READ, mem_memRead=1 and mem_readData is captured at the end of the cycle.
  - In RESP, resp_rdata holds the extracted lane. Little-endian: offset 0 = bits[7:0], half at offset 2 = bits[31:16].
  - Byte/half results are sign- or zero-extended per req_signed; word ignores req_signed.
- Word store: IDLE -> WRITE -> RESP. In WRITE, mem_memWrite=1 and mem_writeData=req_wdata.
- Sub-word store: IDLE -> READ -> WRITE -> RESP.
  - READ captures the old word.
  - WRITE drives the old word with the selected lane replaced by req_wdata[7:0] or [15:0].
- Latency (accept edge to resp_valid cycle): error/no-op 1, load 2, word store 2, sub-word store 3.
- RESP lasts exactly one cycle, then returns to IDLE. There is no response backpressure.
- Strobes:
  - mem_memRead and mem_memWrite are never high in the same cycle.
  - Each strobe is high only in its state, for exactly one cycle per access.
  - mem_addr is held stable from READ through WRITE.
- In IDLE and RESP, all mem_* outputs are 0.
- Reset (including mid-operation): next state IDLE; resp_valid, resp_rdata, resp_error, mem_memRead, mem_memWrite, mem_writeData and mem_addr are 0; the in-flight request is discarded with no write issued.
- Reset takes priority over accept on the same cycle.

Decomposition:
- Shared package mem_access_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - the FSM state enum;
  - lane-offset constants.
- One combinational sub-module, lane_align, provides load extract/extend and store merge from offset, size and signed.
- The FSM, request registers and error check stay in the top.

Test Plan:
- Word store then load: store addr=0x10, wdata=0xDEADBEEF -> mem_memWrite pulse at word 4, resp_valid 2 cycles after accept; then load word 0x10 -> resp_rdata=0xDEADBEEF, error=0.
- Sub-word store and load: memory word 4=0x11223344; store byte 0xAA at addr=0x12 -> one read then one write of 0x11AA3344, resp_valid at cycle 3. Signed byte load at 0x12 -> 0xFFFFFFAA; unsigned byte load -> 0x000000AA.
- Half load at addr=0x12 with word 0x8001FFFF: signed -> 0xFFFF8001; unsigned -> 0x00008001.
- Errors: word load addr=0x11; half store addr=0x13; addr=0x100 with DEPTH=64; size=11; load+store -> each gives resp_error=1, rdata=0, no mem strobes, latency 1.
- Back-to-back streams: req_valid held high for two loads -> second accepted only when req_ready returns in IDLE; responses in order, no overlapping strobes.
- Reset during the READ of a sub-word store -> no mem_memWrite ever asserted, outputs 0 the next cycle, req_ready=1 after reset deasserts, memory unchanged.
